// File: rtl/posit_to_fixed_if.sv
`default_nettype none
// =============================================================================
// Module   : posit_to_fixed_if
// Desc     : Valid/ready bus carrying posit words in and fixed-point results out.
// Revision : 1.0 - initial release
// =============================================================================
interface posit_to_fixed_if #(
  parameter int WIDTH = 8,
  parameter int OW    = 16
);
  logic             vld_i;
  logic             rdy_o;
  logic [WIDTH-1:0] pin;
  logic             vld_o;
  logic             rdy_i;
  logic [OW-1:0]    fix_o;
  logic             sat_o;
  logic             nar_o;

  modport master (
    output vld_i, pin, rdy_i,
    input  rdy_o, vld_o, fix_o, sat_o, nar_o
  );

  modport slave (
    input  vld_i, pin, rdy_i,
    output rdy_o, vld_o, fix_o, sat_o, nar_o
  );
endinterface
`default_nettype wire

// File: rtl/posit_to_fixed.sv
`default_nettype none
// =============================================================================
// Module   : posit_to_fixed
// Desc     : 3-stage posit(WIDTH,EXP) to saturating fixed-point decoder.
//            Define POSIT_TO_FIXED_RNE_EN for round-to-nearest-even.
// Revision : 1.0 - initial release
// =============================================================================
module posit_to_fixed #(
  parameter int WIDTH = 8,
  parameter int EXP   = 1,
  parameter int OW    = 16,
  parameter int FRAC  = 8
) (
  input wire              clk_i,
  input wire              rst,
  posit_to_fixed_if.slave bus
);
  localparam int c_BW  = WIDTH - 1;
  localparam int c_RW  = $clog2(WIDTH);
  localparam int c_SW  = c_RW + EXP + 2;
  localparam int c_MTS = WIDTH - 3 - EXP;
  localparam int c_EFW = EXP + c_MTS;
  localparam int c_XW  = OW + c_MTS + 1;

  logic                   w_adv;
  logic                   r_s1_vld, r_s1_sign, r_s1_zero, r_s1_nar;
  logic [c_BW-1:0]        r_s1_body;
  logic [c_RW-1:0]        r_s1_run;
  logic                   r_s2_vld, r_s2_sign, r_s2_zero, r_s2_nar;
  logic signed [c_SW-1:0] r_s2_sf;
  logic [c_MTS-1:0]       r_s2_frac;
  logic                   r_s3_vld, r_s3_sat, r_s3_nar;
  logic [OW-1:0]          r_s3_fix;

  assign w_adv     = ~r_s3_vld | bus.rdy_i;
  assign bus.rdy_o = w_adv;
  assign bus.vld_o = r_s3_vld;
  assign bus.fix_o = r_s3_fix;
  assign bus.sat_o = r_s3_sat;
  assign bus.nar_o = r_s3_nar;

  // Stage 1: magnitude body and regime run length
  logic [c_BW-1:0] w_body;
  logic [c_RW-1:0] w_run;
  logic            w_stop;
  int              w_cnt;

  assign w_body = c_BW'(bus.pin[WIDTH-1] ? -bus.pin : bus.pin);

  always_comb begin
    w_stop = 1'b0;
    w_cnt  = 0;
    for (int i = c_BW - 1; i >= 0; i--) begin
      if (w_stop || (w_body[i] != w_body[c_BW-1])) w_stop = 1'b1;
      else                                          w_cnt  = w_cnt + 1;
    end
    w_run = c_RW'(w_cnt);
  end

  // Stage 2: strip regime + terminator; exponent and fraction end up left-aligned
  logic [c_EFW-1:0]       w_ef;
  int                     w_k;
  logic signed [c_SW-1:0] w_sf;

  assign w_ef = c_EFW'((r_s1_body << (int'(r_s1_run) + 1)) >> (c_BW - c_EFW));

  always_comb begin
    w_k  = r_s1_body[c_BW-1] ? int'(r_s1_run) - 1 : -int'(r_s1_run);
    w_sf = c_SW'(w_k * (2 ** EXP) + int'(w_ef[c_EFW-1 -: EXP]));
  end

  // Stage 3: w_x holds the magnitude with c_MTS bits below the output LSB
  logic [c_MTS:0]  w_m;
  int              w_a;
  logic [c_XW-1:0] w_x;
  logic            w_ovf;
  logic [OW:0]     w_fm;
  logic [OW+1:0]   w_rmag;
  logic            w_sat;

  assign w_m = {1'b1, r_s2_frac};

  always_comb begin
    w_a   = int'(r_s2_sf) + FRAC;
    w_x   = '0;
    w_ovf = 1'b0;
    if (w_a > OW)                    w_ovf = 1'b1;
    else if (w_a >= 0)               w_x   = c_XW'(w_m) << w_a;
    else if (w_a >= -(c_MTS + FRAC)) w_x   = c_XW'(w_m >> (-w_a));
  end

  assign w_fm = (OW + 1)'(w_x >> c_MTS);

`ifdef POSIT_TO_FIXED_RNE_EN
  logic w_lost, w_up;

  // Bits dropped by a right shift still count towards the sticky bit
  always_comb begin
    w_lost = 1'b0;
    if (w_a < 0) w_lost = |(w_m & ~({(c_MTS + 1){1'b1}} << (-w_a)));
    w_up = w_x[c_MTS-1] & (w_lost | (|(w_x[c_MTS-1:0] << 1)) | w_fm[0]);
  end

  assign w_rmag = {1'b0, w_fm} + (OW + 2)'(w_up);
`else
  assign w_rmag = {1'b0, w_fm};
`endif

  assign w_sat = w_ovf | (|w_rmag[OW+1:OW-1]);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_zero <= 1'b0;
      r_s1_nar  <= 1'b0;
      r_s1_body <= '0;
      r_s1_run  <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_zero <= 1'b0;
      r_s2_nar  <= 1'b0;
      r_s2_sf   <= '0;
      r_s2_frac <= '0;
      r_s3_vld  <= 1'b0;
      r_s3_sat  <= 1'b0;
      r_s3_nar  <= 1'b0;
      r_s3_fix  <= '0;
    end else if (w_adv) begin
      r_s1_vld  <= bus.vld_i;
      r_s1_sign <= bus.pin[WIDTH-1];
      r_s1_zero <= (bus.pin == '0);
      r_s1_nar  <= (bus.pin == {1'b1, {(WIDTH-1){1'b0}}});
      r_s1_body <= w_body;
      r_s1_run  <= w_run;

      r_s2_vld  <= r_s1_vld;
      r_s2_sign <= r_s1_sign;
      r_s2_zero <= r_s1_zero;
      r_s2_nar  <= r_s1_nar;
      r_s2_sf   <= w_sf;
      r_s2_frac <= w_ef[c_MTS-1:0];

      r_s3_vld  <= r_s2_vld;
      if (r_s2_nar) begin
        r_s3_fix <= {1'b1, {(OW-1){1'b0}}};
        r_s3_sat <= 1'b0;
        r_s3_nar <= 1'b1;
      end else if (r_s2_zero) begin
        r_s3_fix <= '0;
        r_s3_sat <= 1'b0;
        r_s3_nar <= 1'b0;
      end else if (w_sat) begin
        r_s3_fix <= r_s2_sign ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        r_s3_sat <= 1'b1;
        r_s3_nar <= 1'b0;
      end else begin
        r_s3_fix <= r_s2_sign ? -w_rmag[OW-1:0] : w_rmag[OW-1:0];
        r_s3_sat <= 1'b0;
        r_s3_nar <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_posit_to_fixed.sv
`default_nettype none
// =============================================================================
// Module   : tb_posit_to_fixed
// Desc     : Directed and random self-checking bench for posit_to_fixed.
// Revision : 1.0 - initial release
// =============================================================================
module tb_posit_to_fixed;
  localparam int WIDTH = 8;
  localparam int EXP   = 1;
  localparam int OW    = 16;
  localparam int FRAC  = 8;
`ifdef POSIT_TO_FIXED_RNE_EN
  localparam logic [OW-1:0] c_R05 = 16'h0002;
`else
  localparam logic [OW-1:0] c_R05 = 16'h0001;
`endif

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  posit_to_fixed_if #(.WIDTH(WIDTH), .OW(OW)) bus ();

  posit_to_fixed #(.WIDTH(WIDTH), .EXP(EXP), .OW(OW), .FRAC(FRAC)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc = 0, outs = 0, first_out = -1, last_out = -1, accepted = 0;
  logic [OW-1:0] q_fix [$];
  logic          q_sat [$];
  logic          q_nar [$];

  logic [WIDTH-1:0] d_pin [11] = '{8'h40, 8'h48, 8'h50, 8'hC0, 8'h7F, 8'h81,
                                   8'h01, 8'h00, 8'h80, 8'h03, 8'h05};
  logic [OW-1:0]    d_fix [11] = '{16'h0100, 16'h0180, 16'h0200, 16'hFF00, 16'h7FFF,
                                   16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, c_R05};
  logic             d_sat [11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
  logic             d_nar [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value = (1 + f) * 2^(k*2^EXP + e), scaled by 2^FRAC and rounded per build
  function automatic void ref_model(input logic [WIDTH-1:0] p, output logic [OW-1:0] fx,
                                    output logic sat, output logic nar);
    logic [WIDTH-1:0] m;
    int  pos, run, k, e, sexp, q;
    real f, w, v;
    fx  = '0;
    sat = 1'b0;
    nar = 1'b0;
    if (p == '0) return;
    if (p == {1'b1, {(WIDTH-1){1'b0}}}) begin
      fx  = {1'b1, {(OW-1){1'b0}}};
      nar = 1'b1;
      return;
    end
    m   = p[WIDTH-1] ? -p : p;
    pos = WIDTH - 2;
    run = 0;
    while (pos >= 0 && m[pos] == m[WIDTH-2]) begin
      run++;
      pos--;
    end
    pos--;
    k = m[WIDTH-2] ? run - 1 : -run;
    e = 0;
    for (int j = 0; j < EXP; j++) begin
      e = e * 2 + ((pos >= 0 && m[pos]) ? 1 : 0);
      pos--;
    end
    f = 1.0;
    w = 0.5;
    while (pos >= 0) begin
      if (m[pos]) f = f + w;
      w = w / 2.0;
      pos--;
    end
    sexp = k * (2 ** EXP) + e + FRAC;
    v = f;
    if (sexp > 0) repeat (sexp) v = v * 2.0;
    else          repeat (-sexp) v = v / 2.0;
    q = $rtoi(v);
`ifdef POSIT_TO_FIXED_RNE_EN
    if ((v - q) > 0.5 || ((v - q) == 0.5 && q[0])) q++;
`endif
    if (q >= (1 << (OW - 1))) begin
      sat = 1'b1;
      fx  = p[WIDTH-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      fx = p[WIDTH-1] ? OW'(-q) : OW'(q);
    end
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check the output handshake and log the input handshake of the current cycle
  task automatic cycle();
    logic [OW-1:0] fx;
    logic s, n;
    #1;
    if (bus.vld_o && bus.rdy_i) begin
      if (q_fix.size() == 0) begin
        chk("unexpected output", 32'(bus.vld_o), 32'd0);
      end else begin
        chk("stream fix", 32'(bus.fix_o), 32'(q_fix.pop_front()));
        chk("stream sat", 32'(bus.sat_o), 32'(q_sat.pop_front()));
        chk("stream nar", 32'(bus.nar_o), 32'(q_nar.pop_front()));
      end
      outs++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (bus.vld_i && bus.rdy_o) begin
      ref_model(bus.pin, fx, s, n);
      q_fix.push_back(fx);
      q_sat.push_back(s);
      q_nar.push_back(n);
      accepted++;
    end
    tick();
    cyc++;
  endtask

  task automatic send_one(input int idx);
    int lat;
    bus.pin   = d_pin[idx];
    bus.vld_i = 1'b1;
    tick();
    bus.vld_i = 1'b0;
    lat = 1;
    while (!bus.vld_o && lat < 10) begin
      tick();
      lat++;
    end
    chk($sformatf("dir %02h latency", d_pin[idx]), 32'(lat), 32'd3);
    chk($sformatf("dir %02h fix", d_pin[idx]), 32'(bus.fix_o), 32'(d_fix[idx]));
    chk($sformatf("dir %02h sat", d_pin[idx]), 32'(bus.sat_o), 32'(d_sat[idx]));
    chk($sformatf("dir %02h nar", d_pin[idx]), 32'(bus.nar_o), 32'(d_nar[idx]));
    tick();
  endtask

  initial begin
    int stale;
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b1;
    bus.pin   = '0;
    rst       = 1'b1;
    tick();
    tick();
    chk("reset vld_o", 32'(bus.vld_o), 32'd0);
    chk("reset fix_o", 32'(bus.fix_o), 32'd0);
    chk("reset sat_o", 32'(bus.sat_o), 32'd0);
    chk("reset nar_o", 32'(bus.nar_o), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) send_one(i);

    // Backpressure: three words, output stalled for five cycles
    bus.pin = 8'h40; bus.vld_i = 1'b1; tick();
    bus.pin = 8'h50; tick();
    bus.pin = 8'hC0; tick();
    bus.pin = 8'h7F;
    bus.rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp rdy_o", 32'(bus.rdy_o), 32'd0);
      chk("bp vld_o", 32'(bus.vld_o), 32'd1);
      chk("bp hold fix", 32'(bus.fix_o), 32'h0100);
      tick();
    end
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b1;
    #1;
    chk("bp out0 vld", 32'(bus.vld_o), 32'd1);
    chk("bp out0 fix", 32'(bus.fix_o), 32'h0100);
    tick();
    chk("bp out1 vld", 32'(bus.vld_o), 32'd1);
    chk("bp out1 fix", 32'(bus.fix_o), 32'h0200);
    tick();
    chk("bp out2 vld", 32'(bus.vld_o), 32'd1);
    chk("bp out2 fix", 32'(bus.fix_o), 32'hFF00);
    tick();
    chk("bp no dup", 32'(bus.vld_o), 32'd0);

    // Full-rate random stream
    cyc = 0; outs = 0; first_out = -1; last_out = -1;
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.vld_i = 1'b1;
      bus.pin   = WIDTH'($urandom);
      cycle();
    end
    bus.vld_i = 1'b0;
    for (int i = 0; i < 10 && q_fix.size() > 0; i++) cycle();
    chk("full drained", 32'(q_fix.size()), 32'd0);
    chk("full count", 32'(outs), 32'd64);
    chk("full gapless", 32'(last_out - first_out + 1), 32'd64);

    // Random valid and ready
    accepted = 0;
    for (int i = 0; i < 1000 && accepted < 64; i++) begin
      bus.vld_i = ($urandom_range(0, 3) != 0);
      bus.rdy_i = ($urandom_range(0, 3) != 0);
      bus.pin   = WIDTH'($urandom);
      cycle();
    end
    chk("rand accepted", 32'(accepted), 32'd64);
    bus.vld_i = 1'b0;
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 20 && q_fix.size() > 0; i++) cycle();
    chk("rand drained", 32'(q_fix.size()), 32'd0);

    // Reset with two words in flight
    bus.pin = 8'h48; bus.vld_i = 1'b1; tick();
    bus.pin = 8'h50; tick();
    bus.vld_i = 1'b0; tick();
    chk("pre-rst vld_o", 32'(bus.vld_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst vld_o", 32'(bus.vld_o), 32'd0);
    chk("rst fix_o", 32'(bus.fix_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.vld_o) stale++;
      tick();
    end
    chk("rst stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
